uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: the downstream partner of the team's UART transmitter. Samples an asynchronous `rx` line at mid-bit using a clock-cycle bit timer, deframes 8N1 frames (8E1 with parity enabled), LSB first, and presents each byte on a valid/ready interface with framing, parity and overrun flags. Sits between the board serial pin and the byte-consuming logic.

---
 rtl/uart_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchronizer, mid-bit sampling, 8N1 deframing, valid/ready output.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int unsigned TIMER_W = 16;
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sample_c, stop_c, par_ok_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_HIGH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      IDLE:      if (!rxs_q) state_d = START;
      START:     if (timer_q == HALF_LAST) state_d = rxs_q ? IDLE : DATA;
      DATA: begin
        if (timer_q == FULL_LAST && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (timer_q == FULL_LAST) state_d = STOP;
`endif
      STOP:      if (timer_q == FULL_LAST) state_d = rxs_q ? IDLE : WAIT_HIGH;
      default:   state_d = WAIT_HIGH;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sample_c    = (timer_q == FULL_LAST);
    stop_c      = (state_q == STOP) && sample_c;
    timer_d     = timer_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
    par_ok_c     = ((^shift_q) == par_q);
    if (state_q == PARITY && sample_c) par_d = rxs_q;
`else
    par_ok_c     = 1'b1;
`endif

    if (state_d != state_q || sample_c || state_q == IDLE || state_q == WAIT_HIGH)
      timer_d = '0;
    if (state_q == START) bit_idx_d = 3'd0;
    if (state_q == DATA && sample_c) begin
      shift_d   = {rxs_q, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (stop_c) begin
      if (!rxs_q) begin
        frame_err_d = 1'b1;
      end else if (!par_ok_c) begin
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b1;
`endif
      end else if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Synchronizer and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      timer_q     <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame table, hand-written corner sequences, random frames.
module tb_uart_receiver;
  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_rise = 0, n_vhigh = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];

  // Event monitor on the inactive edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_vhigh++;
      if (!prev_valid) begin
        n_rise++;
        got_q.push_back(rx_data);
      end
    end
    prev_valid = (rx_valid === 1'b1);
    if (frame_err === 1'b1)  n_ferr++;
    if (parity_err === 1'b1) n_perr++;
    if (overrun === 1'b1)    n_ovr++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       bad_par;
    int         exp_rise;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit((^d) ^ bad_par);
    send_bit(stop_ok);
    rx = 1'b1;
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, " rx_valid"}, rx_valid, 0);
    chk({tag, " rx_data"}, rx_data, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " parity_err"}, parity_err, 0);
    chk({tag, " overrun"}, overrun, 0);
  endtask

  initial begin
    int r0, v0, f0, p0, o0, gi, ef, ep;
    logic [7:0] d;
    logic sbad, pbad;
    logic [7:0] exp_q[$];

    reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_reset("reset");
    reset = 1'b0;
    idle(4);

    // Single-frame table with rx_ready held high
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'h96, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1, 0, 0});
    if (PAR) begin
      vecs.push_back('{8'h07, 1'b1, 1'b0, 1, 0, 0});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 1});
      vecs.push_back('{8'h3E, 1'b0, 1'b1, 0, 1, 0});
    end
    for (int i = 0; i < vecs.size(); i++) begin
      r0 = n_rise; v0 = n_vhigh; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].bad_par);
      idle(2 * CPB);
      chk($sformatf("vec%0d valid_rises", i), n_rise - r0, vecs[i].exp_rise);
      chk($sformatf("vec%0d valid_cycles", i), n_vhigh - v0, vecs[i].exp_rise);
      chk($sformatf("vec%0d frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d parity_err", i), n_perr - p0, vecs[i].exp_perr);
      chk($sformatf("vec%0d overrun", i), n_ovr - o0, 0);
      chk($sformatf("vec%0d valid_idle", i), rx_valid, 0);
      if (vecs[i].exp_rise == 1) chk($sformatf("vec%0d rx_data", i), rx_data, vecs[i].data);
    end

    // Back-to-back frames with consumer stalled
    r0 = n_rise; o0 = n_ovr; f0 = n_ferr;
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("ovr valid_rises", n_rise - r0, 1);
    chk("ovr rx_data", rx_data, 8'h3C);
    chk("ovr rx_valid_held", rx_valid, 1);
    chk("ovr overrun_pulses", n_ovr - o0, 1);
    chk("ovr frame_err", n_ferr - f0, 0);
    rx_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ovr valid_drop", rx_valid, 0);
    chk("ovr data_kept", rx_data, 8'h3C);

    // Stop bit low followed by a held-low line
    r0 = n_rise; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    if (PAR) send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(12 * CPB);
    chk("break frame_err", n_ferr - f0, 1);
    chk("break valid_rises", n_rise - r0, 0);
    chk("break rx_valid", rx_valid, 0);

    // Short glitch on the idle line, then a real frame
    r0 = n_rise; f0 = n_ferr; p0 = n_perr;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(2 * CPB);
    chk("glitch valid_rises", n_rise - r0, 0);
    chk("glitch errors", (n_ferr - f0) + (n_perr - p0), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("glitch next valid_rises", n_rise - r0, 1);
    chk("glitch next rx_data", rx_data, 8'h81);

    // Reset in the middle of a frame
    r0 = n_rise; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    chk_outputs_reset("midreset");
    @(negedge clk);
    reset = 1'b0;
    idle(2 * CPB);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("midreset valid_rises", n_rise - r0, 1);
    chk("midreset rx_data", rx_data, 8'h0F);
    chk("midreset frame_err", n_ferr - f0, 0);

    // Random frames against a frame-level reference model
    gi = got_q.size(); f0 = n_ferr; p0 = n_perr; o0 = n_ovr; ef = 0; ep = 0;
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      sbad = ($urandom_range(7) == 0);
      pbad = PAR && ($urandom_range(7) == 0);
      send_frame(d, !sbad, pbad);
      if (sbad)      ef++;
      else if (pbad) ep++;
      else           exp_q.push_back(d);
      if (sbad) idle(CPB);
      else      idle($urandom_range(CPB));
    end
    idle(2 * CPB);
    chk("rand byte_count", got_q.size() - gi, exp_q.size());
    for (int k = 0; k < exp_q.size() && gi + k < got_q.size(); k++)
      chk($sformatf("rand byte%0d", k), got_q[gi + k], exp_q[k]);
    chk("rand frame_err", n_ferr - f0, ef);
    chk("rand parity_err", n_perr - p0, ep);
    chk("rand overrun", n_ovr - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
